// File: rtl/fc_mac_relu_seq.sv
// Sequential single-MAC fully-connected layer: J*K multiply-accumulates per evaluation.
// Optional macro FC_RELU_EN clamps negative row sums to zero and narrows each row field by one bit.
module fc_mac_relu_seq #(
  parameter int N = 8,
  parameter int J = 3,
  parameter int K = 3,
  parameter int L = 2*N + K - 1,
`ifdef FC_RELU_EN
  localparam int OW = L - 1
`else
  localparam int OW = L
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [J*K*N-1:0]  g_input,
  input  logic [K*N-1:0]    e_input,
  output logic              busy,
  output logic              done,
  output logic [J*OW-1:0]   o
);

  localparam int JW = (J > 1) ? $clog2(J) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [J*K*N-1:0]    w_q, w_d;
  logic [K*N-1:0]      x_q, x_d;
  logic [JW-1:0]       j_q, j_d;
  logic [KW-1:0]       k_q, k_d;
  logic signed [L-1:0] acc_q, acc_d;
  logic [J*OW-1:0]     o_q, o_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic signed [N-1:0]   w_sel;
  logic signed [N-1:0]   x_sel;
  logic signed [2*N-1:0] prod;
  logic signed [L-1:0]   sum;
  logic [OW-1:0]         row_val;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    x_d     = x_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    o_d     = o_q;

    w_sel = w_q[(int'(j_q)*K + int'(k_q))*N +: N];
    x_sel = x_q[int'(k_q)*N +: N];
    prod  = w_sel * x_sel;
    // The signed cast sign-extends the product into the accumulator width.
    sum   = acc_q + L'(prod);
`ifdef FC_RELU_EN
    row_val = sum[L-1] ? '0 : sum[L-2:0];
`else
    row_val = sum;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_d     = g_input;
          x_d     = e_input;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        if (k_q != KW'(K-1)) begin
          acc_d = sum;
          k_d   = k_q + 1'b1;
        end else begin
          o_d[int'(j_q)*OW +: OW] = row_val;
          acc_d = '0;
          k_d   = '0;
          if (j_q == JW'(J-1)) begin
            j_d     = '0;
            state_d = S_DONE;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the state being entered.
    busy_d = (state_d == S_MAC);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      x_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      o_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      x_q     <= x_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign o    = o_q;

endmodule

// File: tb/tb_fc_mac_relu_seq.sv
// Self-checking bench for fc_mac_relu_seq: vector table, corner sequences, random operands vs. a dot-product model.
// Follows FC_RELU_EN the same way as the design.
module tb_fc_mac_relu_seq;

  localparam int N = 8;
  localparam int J = 3;
  localparam int K = 3;
  localparam int L = 2*N + K - 1;
`ifdef FC_RELU_EN
  localparam int OW = L - 1;
`else
  localparam int OW = L;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [J*K*N-1:0]  g_input = '0;
  logic [K*N-1:0]    e_input = '0;
  logic              busy;
  logic              done;
  logic [J*OW-1:0]   o;

  fc_mac_relu_seq #(.N(N), .J(J), .K(K), .L(L)) dut (
    .clk(clk), .rst(rst), .start(start), .g_input(g_input),
    .e_input(e_input), .busy(busy), .done(done), .o(o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_raw [J];

  typedef struct packed {
    logic [J*K*N-1:0] w;
    logic [K*N-1:0]   x;
    logic [J*32-1:0]  exp;   // raw signed dot products, row 0 in the low word
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Reference row function: plain integer dot product, then the row output rule.
  function automatic logic [OW-1:0] f_exp(input int raw);
`ifdef FC_RELU_EN
    return (raw < 0) ? '0 : OW'(raw);
`else
    return OW'(raw);
`endif
  endfunction

  function automatic void model_from_bus(input logic [J*K*N-1:0] w, input logic [K*N-1:0] x);
    for (int j = 0; j < J; j++) begin
      int s = 0;
      for (int k = 0; k < K; k++)
        s += int'($signed(w[(j*K+k)*N +: N])) * int'($signed(x[k*N +: N]));
      exp_raw[j] = s;
    end
  endfunction

  // Called just after the accepting edge. mode 0: drop start; 1: scramble inputs and
  // pulse start at MAC cycle 4; 2: leave start high.
  task automatic wait_done(input int mode, input string tag);
    int  n;
    bit  busy_ok;
    bit  seen;
    @(negedge clk);
    chk({tag, "_accept_busy"}, 64'(busy), 64'd1);
    chk({tag, "_accept_done"}, 64'(done), 64'd0);
    if (mode != 2) start = 1'b0;
    n = 0; busy_ok = 1'b1; seen = 1'b0;
    while (n < 40 && !seen) begin
      if (mode == 1) begin
        g_input = 72'({$urandom, $urandom, $urandom});
        e_input = 24'($urandom);
        start   = (n == 3);
      end
      @(negedge clk);
      n++;
      if (n % K == 0 && n <= J*K)
        chk($sformatf("%s_row%0d_at_edge", tag, n/K-1),
            64'(o[(n/K-1)*OW +: OW]), 64'(f_exp(exp_raw[n/K-1])));
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    if (mode == 1) start = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(J*K));
    chk({tag, "_busy_high_in_mac"}, 64'(busy_ok), 64'd1);
    chk({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
    for (int j = 0; j < J; j++)
      chk($sformatf("%s_row%0d", tag, j), 64'(o[j*OW +: OW]), 64'(f_exp(exp_raw[j])));
  endtask

  initial begin
    // {W22..W00}, {x2,x1,x0}, {row2,row1,row0}
    vecs[0] = '{w: 72'h01_00_00_00_01_00_00_00_01, x: 24'h07FD05,
                exp: {32'sd7, -32'sd3, 32'sd5}};
    vecs[1] = '{w: {9{8'h80}}, x: {3{8'h80}},
                exp: {32'sd49152, 32'sd49152, 32'sd49152}};
    vecs[2] = '{w: 72'h02_00_00_00_02_00_00_00_02, x: 24'h030201,
                exp: {32'sd6, 32'sd4, 32'sd2}};
    vecs[3] = '{w: {9{8'h01}}, x: 24'h05EC0A,
                exp: {-32'sd5, -32'sd5, -32'sd5}};
    vecs[4] = '{w: 72'hFC_03_00_00_00_80_7F_7F_7F, x: 24'h02807F,
                exp: {-32'sd392, -32'sd16256, 32'sd127}};

    // Reset held with start asserted: outputs stay cleared.
    start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      g_input = 72'({$urandom, $urandom, $urandom});
      e_input = 24'($urandom);
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_o", 64'(o), 64'd0);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    // Vector table.
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < J; j++) exp_raw[j] = int'(vecs[v].exp[j*32 +: 32]);
      g_input = vecs[v].w;
      e_input = vecs[v].x;
      start   = 1'b1;
      @(posedge clk);
      wait_done(0, $sformatf("vec%0d", v));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse_len", v), 64'(done), 64'd0);
    end

    // Operand isolation: inputs churn after acceptance and start pulses mid-MAC.
    for (int j = 0; j < J; j++) exp_raw[j] = int'(vecs[4].exp[j*32 +: 32]);
    g_input = vecs[4].w;
    e_input = vecs[4].x;
    start   = 1'b1;
    @(posedge clk);
    wait_done(1, "isolate");
    @(negedge clk);
    chk("isolate_no_restart_busy", 64'(busy), 64'd0);

    // Back-to-back: start held across the done cycle.
    for (int j = 0; j < J; j++) exp_raw[j] = int'(vecs[1].exp[j*32 +: 32]);
    g_input = vecs[1].w;
    e_input = vecs[1].x;
    start   = 1'b1;
    @(posedge clk);
    wait_done(2, "b2b_first");
    for (int j = 0; j < J; j++) exp_raw[j] = int'(vecs[2].exp[j*32 +: 32]);
    g_input = vecs[2].w;
    e_input = vecs[2].x;
    @(posedge clk);
    wait_done(0, "b2b_second");

    // Reset in the middle of an evaluation.
    @(negedge clk);
    for (int j = 0; j < J; j++) exp_raw[j] = int'(vecs[0].exp[j*32 +: 32]);
    g_input = vecs[0].w;
    e_input = vecs[0].x;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_row0_before", 64'(o[0 +: OW]), 64'(f_exp(exp_raw[0])));
    rst = 1'b1;
    #1;
    chk("midrst_o", 64'(o), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      bit saw_done = 1'b0;
      bit saw_busy = 1'b0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
        if (busy) saw_busy = 1'b1;
      end
      chk("midrst_no_done", 64'(saw_done), 64'd0);
      chk("midrst_stays_idle", 64'(saw_busy), 64'd0);
    end
    g_input = vecs[2].w;
    e_input = vecs[2].x;
    model_from_bus(g_input, e_input);
    start = 1'b1;
    @(posedge clk);
    wait_done(0, "midrst_fresh");

    // Random operands against the model.
    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      g_input = 72'({$urandom, $urandom, $urandom});
      e_input = 24'($urandom);
      model_from_bus(g_input, e_input);
      start = 1'b1;
      @(posedge clk);
      wait_done(0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fc_mac_relu_seq.md
# fc_mac_relu_seq

Sequential scheduler for one fully-connected layer with ReLU. It computes the same JxK by Kx1 signed matrix-vector product as the combinational FC-layer blocks, but time-multiplexes a single signed NxN multiplier and an L-bit accumulator over J*K cycles. It suits garbled-circuit flows where one sequential MAC is much cheaper than J*K parallel multipliers. It sits between the layer's operand registers and the next layer's input bus.

## Interface
- N, default 8: operand bit-width, signed two's complement.
- J, default 3: matrix rows, which is also the number of outputs.
- K, default 3: matrix columns, which is also the vector length.
- L, default 2*N+K-1: accumulator width.
- OW, derived: L-1 when FC_RELU_EN is defined, otherwise L. This is the per-row output field width.
- clk, input, 1: the only clock. All flops are rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request to begin a layer evaluation.
- g_input, input, J*K*N: weights. W[j][k] = g_input[(j*K+k)*N +: N].
- e_input, input, K*N: input vector. x[k] = e_input[k*N +: N].
- busy, output, 1: high while the block is in the MAC state.
- done, output, 1: one-cycle pulse; all J output fields are valid while it is high.
- o, output, J*OW: results. Row j is o[j*OW +: OW].

## Operation
- States:
  - IDLE: waiting for start.
  - MAC: one multiply-accumulate per cycle.
  - DONE: lasts exactly one cycle, then the block returns to IDLE.
- Start acceptance:
  - start is sampled in IDLE or DONE.
  - On acceptance: g_input and e_input are latched into internal operand registers, j=0, k=0, acc=0, next state MAC.
  - Inputs may change freely after the accepting edge.
- start in MAC is ignored. There is no queueing.
- Each MAC-state edge:
  - Computes p = W[j][k]*x[k] as a signed 2N-bit product, sign-extended to L bits.
  - Computes sum = acc + p.
  - If k < K-1: acc <= sum and k <= k+1.
  - If k = K-1: o field j <= f(sum), acc <= 0, k <= 0, j <= j+1.
  - When j = J-1 and k = K-1: next state DONE.
- Row output function f, with FC_RELU_EN defined:
  - f(sum) = sum[L-2:0] when sum[L-1]=0.
  - f(sum) = 0 when sum[L-1]=1, so negative sums clamp to zero.
- Width rule: |sum| ≤ K*2^(2N-2) < 2^(L-1), so there is never overflow or truncation of a valid result.
- o fields:
  - Each field holds its value until that row is rewritten.
  - During a new evaluation, rows not yet rewritten keep the previous evaluation's results.
  - o is only guaranteed coherent while done is high.
- Counters j and k wrap to 0 on acceptance. They never exceed J-1 and K-1.

## Timing
- Reset values: busy=0, done=0, o=all zeros; internal state is IDLE with acc=j=k=0.
- Reset asserted at any time, including mid-MAC, forces these values immediately.
  - The current evaluation is abandoned and no done pulse follows.
  - After reset releases, the block waits for a new start.
- Latency: start accepted at edge t.
  - busy is high from after edge t to after edge t+J*K.
  - Row j is written at edge t+(j+1)*K.
  - done is high for the single cycle after edge t+J*K.
- Throughput:
  - start held high during the done cycle is accepted at edge t+J*K+1.
  - Back-to-back evaluations therefore take J*K+1 cycles each.
  - busy rises after that edge and done falls.
- start held continuously high restarts an evaluation every J*K+1 cycles.

## Configuration
- FC_RELU_EN defined:
  - OW = L-1 and ReLU is applied per row.
  - Matches the ReLU FC-layer output format.
- FC_RELU_EN undefined:
  - OW = L and f(sum) = sum, the raw signed accumulator.
  - Used for final or logit layers.
- Sequencing and latency are identical in both configurations.

## Test plan
All scenarios use N=8, J=3, K=3, L=18, with FC_RELU_EN defined unless stated otherwise.
- Reset check: assert rst with start=1 and random inputs -> busy=0, done=0, o=0 throughout.
- Identity matrix: W = identity, x = (5,-3,7), start at edge t.
  - Response: busy for 9 cycles, done in the cycle after edge t+9, o rows = (5,0,7).
  - Without FC_RELU_EN: row 1 = 18'h3FFFD, i.e. -3.
- Extreme operands: all W = -128, all x = -128.
  - Response: every row = 49152 (17'h0C000), with no overflow.
- Input isolation: after acceptance, change g_input/e_input every cycle and pulse start at MAC cycle 4.
  - Response: results come from the latched operands, there is no restart, done comes exactly 9 cycles after acceptance.
- Back-to-back: hold start=1 across done with new operands W = 2*identity, x = (1,2,3).
  - Response: second evaluation is accepted in the done cycle, and its done pulse comes 10 cycles after the first, with o=(2,4,6).
- Mid-operation reset: assert rst at MAC cycle 4.
  - Response: o=0 immediately, no done pulse.
  - A fresh start then yields correct results 9 cycles later.
